// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the FFT frame sequencer:
//     - default transform geometry (N, SIZE, bit_width)
//     - one-hot state encoding of the frame scheduler
//     - bit-reversal helper used to build the memory write address
// ----------------------------------------------------------------------------
package fft_pkg;

    localparam int DEF_N         = 16;
    localparam int DEF_SIZE      = 4;
    localparam int DEF_BIT_WIDTH = 29;

    // Widest index the bit-reversal helper can handle.
    localparam int MAX_SIZE = 16;

    // One-hot encoding: each state owns a single flop bit.
    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_LOAD   = 6'b000010,
        ST_START  = 6'b000100,
        ST_RUN    = 6'b001000,
        ST_DRAIN  = 6'b010000,
        ST_FINISH = 6'b100000
    } state_t;

    // Reverse the lowest 'width' bits of 'value'; bits at or above 'width'
    // come back as zero.
    function automatic logic [MAX_SIZE-1:0] bitrev(input logic [MAX_SIZE-1:0] value,
                                                   input int                  width);
        logic [MAX_SIZE-1:0] result;
        result = '0;
        for (int i = 0; i < MAX_SIZE; i++) begin
            if (i < width) result[i] = value[width-1-i];
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// ----------------------------------------------------------------------------
// fft_bitrev_addr
//   Maps a natural-order sample index to its bit-reversed location in the
//   FFT working memory. Purely combinational.
// Ports
//   idx   in   SIZE     natural-order sample index
//   addr  out  SIZE+1   memory address {1'b0, bitrev(idx)}
// ----------------------------------------------------------------------------
module fft_bitrev_addr
    import fft_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
) (
    input  logic [SIZE-1:0] idx,
    output logic [SIZE:0]   addr
);

    // The top address bit selects the lower bank, where input frames land.
    assign addr = {1'b0, SIZE'(bitrev(MAX_SIZE'(idx), SIZE))};

endmodule

// File: rtl/fft_frame_sequencer.sv
// ----------------------------------------------------------------------------
// fft_frame_sequencer
//   Frame-level scheduler for the sequential FFT core. It loads N samples in
//   bit-reversed order, pulses the FFT start strobe, watches the butterfly
//   passes with a watchdog, then paces readout from downstream ready.
// Ports
//   clk            in   1          rising-edge clock
//   rst            in   1          asynchronous active-high reset
//   s_valid        in   1          input sample valid
//   s_ready        out  1          sequencer accepts a sample
//   s_re, s_im     in   IN_W       signed input sample
//   mem_wr_en      out  1          working-memory write strobe
//   mem_wr_addr    out  SIZE+1     bit-reversed write address
//   mem_wr_re/im   out  bit_width  sign-extended sample
//   flag_start_FFT out  1          one-cycle start pulse to the FFT controller
//   finish_FFT     in   1          butterfly passes complete
//   en_out_data    out  1          advance readout by one sample
//   m_ready        in   1          downstream can take a sample
//   done_o         in   1          readout complete
//   busy           out  1          high in every state except IDLE
//   frame_cnt      out  16         completed frames, wrapping
//   err_timeout    out  1          sticky watchdog error, cleared by rst only
// ----------------------------------------------------------------------------
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int bit_width = DEF_BIT_WIDTH,
    parameter int N         = DEF_N,
    parameter int SIZE      = DEF_SIZE,
    parameter int TIMEOUT   = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [IN_W-1:0]      s_re,
    input  logic signed [IN_W-1:0]      s_im,
    output logic                        mem_wr_en,
    output logic        [SIZE:0]        mem_wr_addr,
    output logic        [bit_width-1:0] mem_wr_re,
    output logic        [bit_width-1:0] mem_wr_im,
    output logic                        flag_start_FFT,
    input  logic                        finish_FFT,
    output logic                        en_out_data,
    input  logic                        m_ready,
    input  logic                        done_o,
    output logic                        busy,
    output logic        [15:0]          frame_cnt,
    output logic                        err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT);

    state_t            state;
    logic [SIZE-1:0]   idx;
    logic [WD_W-1:0]   wd;
    logic [SIZE:0]     wr_addr;
    logic              hs;

    assign hs = s_valid & s_ready;

    fft_bitrev_addr #(
        .SIZE (SIZE)
    ) u_bitrev (
        .idx  (idx),
        .addr (wr_addr)
    );

    assign busy        = (state != ST_IDLE);
    // Readout pacing follows m_ready in the same cycle, but only while draining.
    assign en_out_data = (state == ST_DRAIN) & m_ready;

    // NOTE: every register below is updated with non-blocking assignments so
    // that all of them sample the pre-edge values of one another.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            wd             <= '0;
            s_ready        <= 1'b0;
            mem_wr_en      <= 1'b0;
            mem_wr_addr    <= '0;
            mem_wr_re      <= '0;
            mem_wr_im      <= '0;
            flag_start_FFT <= 1'b0;
            frame_cnt      <= '0;
            err_timeout    <= 1'b0;
        end else begin
            // Write port trails the handshake by one cycle.
            mem_wr_en <= hs;
            if (hs) begin
                mem_wr_addr <= wr_addr;
                mem_wr_re   <= bit_width'(s_re);
                mem_wr_im   <= bit_width'(s_im);
            end

            // Registered strobe: high for the single cycle after START.
            flag_start_FFT <= (state == ST_START);

            case (state)
                ST_IDLE: begin
                    s_ready <= 1'b1;
                    if (hs) begin
                        idx   <= SIZE'(1);
                        state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (hs) begin
                        if (idx == SIZE'(N - 1)) begin
                            // idx is parked at 0 so the next frame starts clean.
                            idx     <= '0;
                            s_ready <= 1'b0;
                            state   <= ST_START;
                        end else begin
                            idx <= idx + SIZE'(1);
                        end
                    end
                end

                ST_START: begin
                    wd    <= '0;
                    state <= ST_RUN;
                end

                ST_RUN: begin
                    // A finish arriving on the expiry cycle still completes the frame.
                    if (finish_FFT) begin
                        state <= ST_DRAIN;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        s_ready     <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end

                ST_DRAIN: begin
                    if (done_o) state <= ST_FINISH;
                end

                ST_FINISH: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    s_ready   <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: begin
                    s_ready <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_fft_frame_sequencer
//   Drives random and ramp frames into the sequencer, plays the FFT
//   controller and the downstream sink, and checks every memory write and
//   control output against an index-level model of the frame protocol.
// ----------------------------------------------------------------------------
module tb_fft_frame_sequencer;

    localparam int IN_W    = 16;
    localparam int BW      = 29;
    localparam int N       = 16;
    localparam int SIZE    = 4;
    localparam int AW      = SIZE + 1;
    localparam int TIMEOUT = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   s_valid;
    logic                   s_ready;
    logic signed [IN_W-1:0] s_re;
    logic signed [IN_W-1:0] s_im;
    logic                   mem_wr_en;
    logic [AW-1:0]          mem_wr_addr;
    logic [BW-1:0]          mem_wr_re;
    logic [BW-1:0]          mem_wr_im;
    logic                   flag_start_FFT;
    logic                   finish_FFT;
    logic                   en_out_data;
    logic                   m_ready;
    logic                   done_o;
    logic                   busy;
    logic [15:0]            frame_cnt;
    logic                   err_timeout;

    always #5 clk = ~clk;

    fft_frame_sequencer #(
        .IN_W      (IN_W),
        .bit_width (BW),
        .N         (N),
        .SIZE      (SIZE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_re           (s_re),
        .s_im           (s_im),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_re      (mem_wr_re),
        .mem_wr_im      (mem_wr_im),
        .flag_start_FFT (flag_start_FFT),
        .finish_FFT     (finish_FFT),
        .en_out_data    (en_out_data),
        .m_ready        (m_ready),
        .done_o         (done_o),
        .busy           (busy),
        .frame_cnt      (frame_cnt),
        .err_timeout    (err_timeout)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] re;
        logic [BW-1:0] im;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    wr_t         exp_q[$];
    int          n_acc;
    int          n_writes;
    logic [15:0] exp_frames;
    logic        exp_err;
    logic [BW-1:0] obs_re [N];
    logic [BW-1:0] obs_im [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Index k lands at the address whose SIZE bits are k read backwards.
    function automatic int ref_bitrev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < SIZE; b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    function automatic logic [BW-1:0] ref_sext(input logic signed [IN_W-1:0] v);
        int t;
        t = int'(v);
        return BW'(t);
    endfunction

    // Write monitor: every mem_wr_en cycle must match the next accepted sample.
    always @(negedge clk) begin : mon
        wr_t e;
        if (mem_wr_en === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(mem_wr_addr), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_wr_addr), 64'(e.addr));
                check("wr_re",   64'(mem_wr_re),   64'(e.re));
                check("wr_im",   64'(mem_wr_im),   64'(e.im));
            end
            obs_re[mem_wr_addr[SIZE-1:0]] = mem_wr_re;
            obs_im[mem_wr_addr[SIZE-1:0]] = mem_wr_im;
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_sample(input logic signed [IN_W-1:0] re,
                               input logic signed [IN_W-1:0] im,
                               output int waits);
        wr_t e;
        waits   = 0;
        s_valid = 1'b1;
        s_re    = re;
        s_im    = im;
        while (s_ready !== 1'b1 && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (s_ready !== 1'b1) begin
            check("s_ready_timeout", 64'(s_ready), 64'(1));
        end else begin
            e.addr = AW'(ref_bitrev(n_acc));
            e.re   = ref_sext(re);
            e.im   = ref_sext(im);
            exp_q.push_back(e);
            n_acc++;
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // finish_at == 0 means the controller never reports completion.
    task automatic run_frame(input bit ramp, input bit gaps, input int finish_at, input bit rand_ready);
        int waits, c, cyc, adv, en_cnt, run_len;
        logic signed [IN_W-1:0] re, im;
        n_acc    = 0;
        n_writes = 0;
        for (int k = 0; k < N; k++) begin
            re = ramp ? IN_W'(k)  : IN_W'($urandom());
            im = ramp ? IN_W'(-k) : IN_W'($urandom());
            send_sample(re, im, waits);
            if (k > 0) check("s_ready_load", 64'(waits), 64'(0));
            if (gaps && k < N - 1) @(negedge clk);
        end
        // Last write is visible now; the start strobe must follow next cycle.
        check("flag_before", 64'(flag_start_FFT), 64'(0));
        check("s_ready_drop", 64'(s_ready), 64'(0));
        s_valid = 1'b1;
        s_re    = IN_W'($urandom());
        @(negedge clk);
        check("flag_pulse", 64'(flag_start_FFT), 64'(1));
        check("n_writes", 64'(n_writes), 64'(N));
        check("busy_run", 64'(busy), 64'(1));
        m_ready = 1'b1;
        c       = 1;
        run_len = (finish_at == 0) ? TIMEOUT : finish_at;
        while (c < run_len) begin
            @(negedge clk);
            c++;
            if (c == 2) begin
                check("flag_one_cycle", 64'(flag_start_FFT), 64'(0));
                check("s_ready_run", 64'(s_ready), 64'(0));
                #1 check("en_in_run", 64'(en_out_data), 64'(0));
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        if (finish_at == 0) begin
            check("err_before_expiry", 64'(err_timeout), 64'(exp_err));
            @(negedge clk);
            exp_err = 1'b1;
            check("err_timeout", 64'(err_timeout), 64'(exp_err));
            check("busy_after_timeout", 64'(busy), 64'(0));
            check("s_ready_after_timeout", 64'(s_ready), 64'(1));
            check("frames_after_timeout", 64'(frame_cnt), 64'(exp_frames));
        end else begin
            finish_FFT = 1'b1;
            @(negedge clk);
            finish_FFT = 1'b0;
            check("busy_drain", 64'(busy), 64'(1));
            check("err_finish_wins", 64'(err_timeout), 64'(exp_err));
            adv    = 0;
            cyc    = 0;
            en_cnt = 0;
            while (adv < N && cyc < 200) begin
                m_ready = rand_ready ? 1'($urandom_range(0, 1)) : (cyc % 4 != 3);
                done_o  = m_ready && (adv == N - 1);
                #1;
                if (en_out_data === 1'b1) en_cnt++;
                if (done_o) check("en_with_done", 64'(en_out_data), 64'(1));
                if (m_ready) adv++;
                @(negedge clk);
                cyc++;
            end
            done_o = 1'b0;
            check("en_count", 64'(en_cnt), 64'(N));
            m_ready = 1'b1;
            #1 check("en_gated_finish", 64'(en_out_data), 64'(0));
            check("busy_finish", 64'(busy), 64'(1));
            check("frames_in_finish", 64'(frame_cnt), 64'(exp_frames));
            m_ready = 1'b0;
            @(negedge clk);
            exp_frames = exp_frames + 16'd1;
            check("busy_idle", 64'(busy), 64'(0));
            check("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
            check("s_ready_idle", 64'(s_ready), 64'(1));
            check("err_sticky", 64'(err_timeout), 64'(exp_err));
        end
    endtask

    task automatic reset_mid_frame();
        int waits;
        n_acc    = 0;
        n_writes = 0;
        for (int k = 0; k < 7; k++) send_sample(IN_W'($urandom()), IN_W'($urandom()), waits);
        m_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_mid_ctrl",
              64'({s_ready, mem_wr_en, mem_wr_addr, flag_start_FFT, en_out_data, busy, frame_cnt, err_timeout}),
              64'(0));
        check("rst_mid_data", 64'({mem_wr_re, mem_wr_im}), 64'(0));
        check("partial_writes", 64'(n_writes), 64'(7));
        m_ready    = 1'b0;
        exp_q.delete();
        exp_frames = '0;
        exp_err    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        s_valid    = 1'b0;
        s_re       = '0;
        s_im       = '0;
        finish_FFT = 1'b0;
        m_ready    = 1'b0;
        done_o     = 1'b0;
        exp_frames = '0;
        exp_err    = 1'b0;
        n_writes   = 0;
        #12;
        check("rst_ctrl",
              64'({s_ready, mem_wr_en, mem_wr_addr, flag_start_FFT, en_out_data, busy, frame_cnt, err_timeout}),
              64'(0));
        check("rst_data", 64'({mem_wr_re, mem_wr_im}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(s_ready), 64'(1));
        check("idle_busy", 64'(busy), 64'(0));

        // Ramp frame, back-to-back, 3-of-4 ready pattern.
        run_frame(1'b1, 1'b0, 20, 1'b0);
        check("im_minus_one", 64'(obs_im[8]), 64'(29'h1FFF_FFFF));
        check("re_idx15", 64'(obs_re[15]), 64'(15));

        // Random data with valid gaps and random downstream ready.
        run_frame(1'b0, 1'b1, 20, 1'b1);

        // Controller strobes outside their windows must be ignored.
        finish_FFT = 1'b1;
        done_o     = 1'b1;
        repeat (3) @(negedge clk);
        finish_FFT = 1'b0;
        done_o     = 1'b0;
        check("spurious_busy", 64'(busy), 64'(0));
        check("spurious_flag", 64'(flag_start_FFT), 64'(0));
        check("spurious_frames", 64'(frame_cnt), 64'(exp_frames));

        // Watchdog expiry, then finish exactly on the expiry cycle.
        run_frame(1'b0, 1'b0, 0, 1'b1);
        run_frame(1'b0, 1'b0, TIMEOUT, 1'b1);

        // Reset in the middle of loading, then a clean frame.
        reset_mid_frame();
        run_frame(1'b0, 1'b0, 5, 1'b1);

        // Frame counter wrap.
        force dut.frame_cnt = 16'hFFFE;
        #1 release dut.frame_cnt;
        exp_frames = 16'hFFFE;
        check("frame_preset", 64'(frame_cnt), 64'(exp_frames));
        run_frame(1'b0, 1'b0, 3, 1'b1);
        run_frame(1'b0, 1'b1, 7, 1'b1);
        check("frame_wrap", 64'(frame_cnt), 64'(0));
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
